// File: rtl/fa_stream_pkg.sv
// Shared definitions for the serial full-adder stream (sequencer and receiver).
// Holds the phase encoding both ends must agree on, the default word width
// and a helper giving the frame length in clock cycles.
package fa_stream_pkg;

  // Phase loop encoding, identical on sequencer and receiver
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    P1   = 2'b01,
    P2   = 2'b10,
    P3   = 2'b11
  } fa_state_e;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // Cycles per frame: each 3-cycle loop carries 2 sum and 2 carry bits
  function automatic int unsigned frame_len(input int unsigned w);
    return (3 * w) / 2;
  endfunction

endpackage

// File: rtl/fa_stream_shreg.sv
// WIDTH-bit right-shift register, serial data entering at the MSB.
// Ports: clk, rst (sync, active-high), clear (sync clear), shift_en, sin
// (serial in), shifted_c (contents as they will be after this cycle's shift).
module fa_stream_shreg
  import fa_stream_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             sin,
  output logic [WIDTH-1:0] shifted_c
);

  logic [WIDTH-1:0] q;

  // Lets the owner capture a completed word on the same edge as the last shift
  assign shifted_c = {sin, q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      q <= '0;
    end else if (shift_en) begin
      q <= shifted_c;
    end
  end

endmodule

// File: rtl/fa_stream_rx.sv
// Receive side of the serial full-adder stream. Follows the sequencer's
// P1 -> P2 -> P3 phase loop from the shared start/abort controls, gathers
// S and COUT into WIDTH-bit words and flags outputs seen in a phase where
// the sequencer must hold them at 0.
// Ports: CLK, RST (sync, active-high), start, abort, S, COUT inputs;
// sum_word, carry_word (last completed frame), valid (1-cycle pulse),
// busy (not IDLE), proto_err (sticky violation flag) outputs.
module fa_stream_rx
  import fa_stream_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic             abort,
  input  logic             S,
  input  logic             COUT,
  output logic [WIDTH-1:0] sum_word,
  output logic [WIDTH-1:0] carry_word,
  output logic             valid,
  output logic             busy,
  output logic             proto_err
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  fa_state_e        state;
  logic [CW-1:0]    sum_cnt;
  logic [CW-1:0]    carry_cnt;
  logic [CW-1:0]    sum_cnt_inc;
  logic [CW-1:0]    carry_cnt_inc;
  logic [WIDTH-1:0] sum_next;
  logic [WIDTH-1:0] carry_next;
  logic             frame_clr;
  logic             sum_shift;
  logic             carry_shift;
  logic             frame_done;

  assign frame_clr     = (state == IDLE) && start;
  assign sum_shift     = !abort && ((state == P1) || (state == P3));
  assign carry_shift   = !abort && ((state == P2) || (state == P3));
  assign sum_cnt_inc   = sum_cnt + CW'(1);
  assign carry_cnt_inc = carry_cnt + CW'(1);
  // Both counts hit WIDTH together on a P3 cycle
  assign frame_done    = (state == P3) && (sum_cnt_inc == CW'(WIDTH)) &&
                         (carry_cnt_inc == CW'(WIDTH));

  fa_stream_shreg #(.WIDTH(WIDTH)) u_sum_sr (
    .clk       (CLK),
    .rst       (RST),
    .clear     (frame_clr),
    .shift_en  (sum_shift),
    .sin       (S),
    .shifted_c (sum_next)
  );

  fa_stream_shreg #(.WIDTH(WIDTH)) u_carry_sr (
    .clk       (CLK),
    .rst       (RST),
    .clear     (frame_clr),
    .shift_en  (carry_shift),
    .sin       (COUT),
    .shifted_c (carry_next)
  );

  // Phase tracking, bit counting, error flag and output words
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      sum_cnt    <= '0;
      carry_cnt  <= '0;
      sum_word   <= '0;
      carry_word <= '0;
      valid      <= 1'b0;
      busy       <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= P1;
            busy      <= 1'b1;
            sum_cnt   <= '0;
            carry_cnt <= '0;
            proto_err <= 1'b0;
          end
        end
        P1: begin
          if (COUT) proto_err <= 1'b1;
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state   <= P2;
            sum_cnt <= sum_cnt_inc;
          end
        end
        P2: begin
          if (S) proto_err <= 1'b1;
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state     <= P3;
            carry_cnt <= carry_cnt_inc;
          end
        end
        P3: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state <= P1;
            if (frame_done) begin
              // Next frame starts in the following P1 with no gap
              valid      <= 1'b1;
              sum_word   <= sum_next;
              carry_word <= carry_next;
              sum_cnt    <= '0;
              carry_cnt  <= '0;
            end else begin
              sum_cnt   <= sum_cnt_inc;
              carry_cnt <= carry_cnt_inc;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
